// File: rtl/core_pkg.sv
// Shared encodings for the memory stage: result-source select, load/store funct3 and the
// memory-access FSM state.
package core_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

    typedef enum logic [1:0] {
        RES_ALU       = 2'd0,
        RES_MEM       = 2'd1,
        RES_PC_PLUS   = 2'd2,
        RES_LUI_AUIPC = 2'd3
    } result_src_e;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } mem_state_e;

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a loaded word and sign- or zero-extends it.
module load_align
    import core_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (offset)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

        data = '0;
        case (funct3)
            F3_B:    data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_H:    data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_W:    data = rdata;
            F3_BU:   data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_HU:   data = {{(XLEN-16){1'b0}}, half_sel};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/stage_memory.sv
// Pipeline memory stage: issues load/store requests on a valid/ready data port and
// registers results to writeback. Optional alignment trap under MISALIGN_TRAP_EN.
module stage_memory
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] execute_alu_result,
    input  logic [XLEN-1:0] execute_wr_datamem_data,
    input  logic            execute_datamem_wr_enable,
    input  logic [1:0]      execute_result_src,
    input  logic [2:0]      execute_funct3,
    input  logic [4:0]      execute_rd,
    input  logic            execute_regfile_wr_enable,
    input  logic [XLEN-1:0] execute_instr_addr_plus,
    output logic            mem_stall,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic [XLEN-1:0] dmem_addr,
    output logic            dmem_we,
    output logic [BE_W-1:0] dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [4:0]      mem_rd,
    output logic            mem_regfile_wr_enable,
    output logic [1:0]      mem_result_src,
    output logic [XLEN-1:0] mem_alu_result,
    output logic [XLEN-1:0] mem_instr_addr_plus,
    output logic [XLEN-1:0] mem_read_data,
    output logic            mem_misalign
);

    mem_state_e      state;
    logic            is_store;
    logic            is_load;
    logic            misalign;
    logic            mem_op;
    logic            done;
    logic [XLEN-1:0] load_data;

    // Access classification, completion and stall; execute holds its outputs while stalled
    always_comb begin
        is_store = execute_datamem_wr_enable;
        is_load  = (execute_result_src == RES_MEM) && !is_store;
`ifdef MISALIGN_TRAP_EN
        misalign = (is_load || is_store) &&
                   ((((execute_funct3 == F3_H) || (execute_funct3 == F3_HU)) && execute_alu_result[0]) ||
                    ((execute_funct3 == F3_W) && (execute_alu_result[1:0] != 2'b00)));
`else
        misalign = 1'b0;
`endif
        mem_op = (is_load || is_store) && !misalign;
        done   = (is_store && dmem_req_ready && (state != ST_WAIT)) ||
                 (is_load && dmem_rsp_valid && (state == ST_WAIT));
        mem_stall      = rst_n && mem_op && !done;
        dmem_req_valid = rst_n && (((state == ST_IDLE) && mem_op) || (state == ST_REQ));
    end

    // Word address and lane steering for stores
    always_comb begin
        dmem_addr = {execute_alu_result[XLEN-1:2], 2'b00};
        dmem_we   = is_store;
        case (execute_funct3[1:0])
            2'b00: begin
                dmem_be    = BE_W'(4'b0001 << execute_alu_result[1:0]);
                dmem_wdata = {4{execute_wr_datamem_data[7:0]}};
            end
            2'b01: begin
                dmem_be    = BE_W'(4'b0011 << {execute_alu_result[1], 1'b0});
                dmem_wdata = {2{execute_wr_datamem_data[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = execute_wr_datamem_data;
            end
        endcase
    end

    load_align u_load_align (
        .funct3 (execute_funct3),
        .offset (execute_alu_result[1:0]),
        .rdata  (dmem_rdata),
        .data   (load_data)
    );

    // Access FSM and registered writeback outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                 <= ST_IDLE;
            mem_rd                <= '0;
            mem_regfile_wr_enable <= 1'b0;
            mem_result_src        <= '0;
            mem_alu_result        <= '0;
            mem_instr_addr_plus   <= '0;
            mem_read_data         <= '0;
            mem_misalign          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_op) begin
                        if (dmem_req_ready) state <= is_load ? ST_WAIT : ST_IDLE;
                        else                state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (dmem_req_ready) state <= is_load ? ST_WAIT : ST_IDLE;
                end
                ST_WAIT: begin
                    if (dmem_rsp_valid) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            mem_rd              <= execute_rd;
            mem_result_src      <= execute_result_src;
            mem_alu_result      <= execute_alu_result;
            mem_instr_addr_plus <= execute_instr_addr_plus;
            if (mem_stall) begin
                mem_regfile_wr_enable <= 1'b0;
                mem_misalign          <= 1'b0;
                mem_read_data         <= '0;
            end else begin
                mem_regfile_wr_enable <= execute_regfile_wr_enable && !misalign;
                mem_misalign          <= misalign;
                mem_read_data         <= (is_load && !misalign) ? load_data : '0;
            end
        end
    end

endmodule
